// File: rtl/divider_arbiter.sv
// Round-robin arbiter that shares one 8-bit sequential divider among NUM_REQ requesters.
// Build option DIV_ARB_ZERO_BYPASS_EN answers divide-by-zero requests directly, leaving the divider idle.
module divider_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [8*NUM_REQ-1:0]   req_dividend,
    input  logic [8*NUM_REQ-1:0]   req_divisor,
    output logic [NUM_REQ-1:0]     resp_valid,
    output logic [7:0]             resp_quotient,
    output logic [7:0]             resp_remainder,
    output logic                   resp_div_zero,
    output logic                   busy,
    output logic                   div_start,
    output logic [7:0]             div_dividend,
    output logic [7:0]             div_divisor,
    input  logic [7:0]             div_quotient,
    input  logic [7:0]             div_remainder,
    input  logic                   div_ready
);
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] owner_q, owner_d;

    logic [IDX_W-1:0] win_idx;
    logic             win_found;
    logic [IDX_W:0]   cand;
    logic [7:0]       dividend_arr [NUM_REQ];
    logic [7:0]       divisor_arr  [NUM_REQ];
    logic [7:0]       win_dividend;
    logic [7:0]       win_divisor;
    logic             win_zero;
    logic             accept;

    logic [7:0]       div_dividend_q, div_divisor_q;
    logic [7:0]       resp_quotient_q, resp_remainder_q;
    logic             div_zero_q;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign dividend_arr[gi] = req_dividend[8*gi +: 8];
            assign divisor_arr[gi]  = req_divisor[8*gi +: 8];
        end
    endgenerate

    // Rotating priority search: first pending requester at or above rr_ptr, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!win_found && req_valid[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    assign win_dividend = dividend_arr[win_idx];
    assign win_divisor  = divisor_arr[win_idx];
    assign win_zero     = (win_divisor == 8'd0);
    assign accept       = (state_q == IDLE) && win_found;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    owner_d  = win_idx;
                    rr_ptr_d = (win_idx == IDX_W'(NUM_REQ-1)) ? '0 : win_idx + IDX_W'(1);
`ifdef DIV_ARB_ZERO_BYPASS_EN
                    state_d  = win_zero ? RESP : ISSUE;
`else
                    state_d  = ISSUE;
`endif
                end
            end
            ISSUE:   state_d = WAIT;
            // div_ready is only looked at from WAIT on; during ISSUE it still reflects the previous op.
            WAIT:    if (div_ready) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_dividend_q   <= '0;
            div_divisor_q    <= '0;
            div_zero_q       <= 1'b0;
            resp_quotient_q  <= '0;
            resp_remainder_q <= '0;
        end else begin
            if (accept) begin
                div_dividend_q <= win_dividend;
                div_divisor_q  <= win_divisor;
                div_zero_q     <= win_zero;
`ifdef DIV_ARB_ZERO_BYPASS_EN
                if (win_zero) begin
                    resp_quotient_q  <= 8'hFF;
                    resp_remainder_q <= win_dividend;
                end
`endif
            end
            if ((state_q == WAIT) && div_ready) begin
                resp_quotient_q  <= div_quotient;
                resp_remainder_q <= div_remainder;
            end
        end
    end

    always_comb begin
        req_ready     = '0;
        resp_valid    = '0;
        div_start     = 1'b0;
        resp_div_zero = 1'b0;
        busy          = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (win_found && !rst) begin
                    req_ready[win_idx] = 1'b1;
                end
            end
            ISSUE: div_start = 1'b1;
            RESP: begin
                resp_valid[owner_q] = 1'b1;
                resp_div_zero       = div_zero_q;
            end
            default: ;
        endcase
    end

    assign div_dividend   = div_dividend_q;
    assign div_divisor    = div_divisor_q;
    assign resp_quotient  = resp_quotient_q;
    assign resp_remainder = resp_remainder_q;
endmodule
